// File: rtl/config_pkg.sv
// Subsystem configuration shared by the core-side blocks.
// XLEN            : datapath width of operands and results.
// CSR_QUEUE_DEPTH : number of pending CSR entries in the top-level csr_queue instance.
// fu_data_t       : default functional-unit payload (operand_a, operand_b, trans_id).
package config_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned CSR_QUEUE_DEPTH = 2;
  localparam int unsigned FU_TRANS_ID_W   = 3;

  typedef struct packed {
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [FU_TRANS_ID_W-1:0] trans_id;
  } fu_data_t;

endpackage

// File: rtl/csr_queue.sv
// CSR queue: buffers the addresses of issued CSR instructions until the commit stage retires
// them in order. The operand_a/trans_id result is handed back to writeback in the issue cycle.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop every pending entry
//   fu_data_i              operands; operand_b[11:0] is the CSR address
//   csr_valid_i/ready_o    issue handshake (push = valid & ready)
//   csr_result_o           operand_a passthrough
//   csr_trans_id_o         trans_id passthrough
//   csr_result_valid_o     push accepted this cycle
//   csr_commit_i           retire the oldest entry
//   csr_addr_o/valid_o     address of the oldest entry and whether it is live
//   csr_commit_err_o       registered pulse: a commit arrived while the queue was empty
//   csr_count_o            number of live entries
module csr_queue
  import config_pkg::*;
#(
  parameter type         fu_data_t     = config_pkg::fu_data_t,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  localparam int unsigned CntW         = $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     csr_valid_i,
  output logic                     csr_ready_o,
  output logic [XLEN-1:0]          csr_result_o,
  output logic [TRANS_ID_BITS-1:0] csr_trans_id_o,
  output logic                     csr_result_valid_o,
  input  logic                     csr_commit_i,
  output logic [11:0]              csr_addr_o,
  output logic                     csr_addr_valid_o,
  output logic                     csr_commit_err_o,
  output logic [CntW-1:0]          csr_count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("csr_queue: DEPTH must be within 1..16");
  end

  typedef struct packed {
    logic [11:0] addr;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PtrW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               err_q, err_d;
  logic               ready, push, pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    // A commit frees a slot in the same cycle, so a full queue can still accept.
    ready   = ~flush_i & ((count_q < CntW'(DEPTH)) | csr_commit_i);
    push    = csr_valid_i & ready;
    pop     = csr_commit_i & (count_q != '0) & ~flush_i;
    err_d   = csr_commit_i & (count_q == '0) & ~flush_i;
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q].addr = fu_data_i.operand_b[11:0];
        wr_d             = next_ptr(wr_q);
      end
      if (pop) begin
        rd_d = next_ptr(rd_q);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Only the CSR address field of operand_b is stored.
  logic unused_operand_b;
  assign unused_operand_b = ^fu_data_i.operand_b[XLEN-1:12];

  assign csr_ready_o        = ready;
  assign csr_result_valid_o = push;
  assign csr_result_o       = fu_data_i.operand_a;
  assign csr_trans_id_o     = TRANS_ID_BITS'(fu_data_i.trans_id);
  assign csr_addr_o         = mem_q[rd_q].addr;
  assign csr_addr_valid_o   = (count_q != '0);
  assign csr_commit_err_o   = err_q;
  assign csr_count_o        = count_q;

endmodule
